// File: rtl/vga_pkg.sv
// Shared timing defaults, color type and channel expansion for the VGA scanout block.
package vga_pkg;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_PIPE_LAT  = 0;

    typedef logic [5:0] color6_t;

    localparam color6_t DEF_BG_COLOR = 6'h00;

    // Replicating the 2-bit code spans the full 8-bit DAC range evenly.
    function automatic logic [7:0] expand2(logic [1:0] k);
        return {4{k}};
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a configurable reset pattern; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{clk_i, rst_i, en_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stage_q <= {DEPTH{RST_VAL}};
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/vga_scanout.sv
// 640x480@60 raster generator: exports coordinates to the sprite mapper and drives the DAC
// with sync/blank delayed to match the mapper's pipeline latency.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int      H_VISIBLE = DEF_H_VISIBLE,
    parameter int      H_FRONT   = DEF_H_FRONT,
    parameter int      H_SYNC    = DEF_H_SYNC,
    parameter int      H_BACK    = DEF_H_BACK,
    parameter int      V_VISIBLE = DEF_V_VISIBLE,
    parameter int      V_FRONT   = DEF_V_FRONT,
    parameter int      V_SYNC    = DEF_V_SYNC,
    parameter int      V_BACK    = DEF_V_BACK,
    parameter int      PIPE_LAT  = DEF_PIPE_LAT,
    parameter color6_t BG_COLOR  = DEF_BG_COLOR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  color,
    input  logic        draw,
    output logic [10:0] vga_x,
    output logic [10:0] vga_y,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);
    localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);

    logic        pix_div_q;
    logic        pix_en;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hs_raw, vs_raw, vis_raw;
    logic [2:0]  dly;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    color6_t     c;

    assign pix_en = pix_div_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    assign hs_raw  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    assign vs_raw  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    assign vis_raw = (h_q < H_VIS) && (v_q < V_VIS);

    // Sync/blank wait here for the mapper to catch up with the same coordinate.
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (3'b110)
    ) u_dly (
        .clk_i (Clk),
        .rst_i (Reset),
        .en_i  (pix_en),
        .d_i   ({hs_raw, vs_raw, vis_raw}),
        .q_o   (dly)
    );

    always_comb begin
        c         = draw ? color : BG_COLOR;
        hs_d      = dly[2];
        vs_d      = dly[1];
        blank_n_d = dly[0];
        r_d       = '0;
        g_d       = '0;
        b_d       = '0;
        if (dly[0]) begin
            r_d = expand2(c[5:4]);
            g_d = expand2(c[3:2]);
            b_d = expand2(c[1:0]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_div_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            pix_div_q <= ~pix_div_q;
            h_q       <= h_d;
            v_q       <= v_d;
            if (pix_en) begin
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blank_n_q <= blank_n_d;
                r_q       <= r_d;
                g_q       <= g_d;
                b_q       <= b_d;
            end
        end
    end

    assign vga_x       = h_q;
    assign vga_y       = v_q;
    assign frame_start = pix_en && (h_q == '0) && (v_q == '0);
    assign VGA_CLK     = pix_div_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: three configurations checked every Clk against a cycle-count raster model.
module tb_vga_scanout;
    localparam int N = 3;
    localparam int CFG_HV  [N] = '{640, 640, 8};
    localparam int CFG_HF  [N] = '{16, 16, 2};
    localparam int CFG_HS  [N] = '{96, 96, 3};
    localparam int CFG_HB  [N] = '{48, 48, 2};
    localparam int CFG_VV  [N] = '{480, 480, 4};
    localparam int CFG_VF  [N] = '{10, 10, 1};
    localparam int CFG_VS  [N] = '{2, 2, 2};
    localparam int CFG_VB  [N] = '{33, 33, 2};
    localparam int CFG_LAT [N] = '{0, 2, 1};
    localparam logic [5:0] CFG_BG [N] = '{6'h00, 6'h3F, 6'h15};

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
    } pins_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [5:0]  col [N];
    logic        drw [N];
    logic [10:0] vx [N];
    logic [10:0] vy [N];
    logic        fs [N];
    logic        vclk [N];
    logic        hs [N];
    logic        vs [N];
    logic        bl [N];
    logic        sn [N];
    logic [7:0]  r [N];
    logic [7:0]  g [N];
    logic [7:0]  b [N];

    int t = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    always #10 Clk = ~Clk;

    vga_scanout dA (
        .Clk(Clk), .Reset(Reset), .color(col[0]), .draw(drw[0]),
        .vga_x(vx[0]), .vga_y(vy[0]), .frame_start(fs[0]), .VGA_CLK(vclk[0]),
        .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bl[0]), .VGA_SYNC_N(sn[0]),
        .VGA_R(r[0]), .VGA_G(g[0]), .VGA_B(b[0])
    );

    vga_scanout #(.PIPE_LAT(2), .BG_COLOR(6'h3F)) dB (
        .Clk(Clk), .Reset(Reset), .color(col[1]), .draw(drw[1]),
        .vga_x(vx[1]), .vga_y(vy[1]), .frame_start(fs[1]), .VGA_CLK(vclk[1]),
        .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bl[1]), .VGA_SYNC_N(sn[1]),
        .VGA_R(r[1]), .VGA_G(g[1]), .VGA_B(b[1])
    );

    vga_scanout #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .PIPE_LAT(1), .BG_COLOR(6'h15)
    ) dC (
        .Clk(Clk), .Reset(Reset), .color(col[2]), .draw(drw[2]),
        .vga_x(vx[2]), .vga_y(vy[2]), .frame_start(fs[2]), .VGA_CLK(vclk[2]),
        .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bl[2]), .VGA_SYNC_N(sn[2]),
        .VGA_R(r[2]), .VGA_G(g[2]), .VGA_B(b[2])
    );

    // Edges seen with Reset low since the last reset edge.
    always @(posedge Clk) t <= Reset ? 0 : t + 1;

    // Sprite-mapper stand-in: returns {draw, color} for a coordinate.
    function automatic logic [6:0] mapper(int x, int y);
        if (x == 10 && y == 5) return {1'b1, 6'b110100};
        if (x >= 640) return {1'b1, 6'h3F};
        return {((x + y) % 4) != 0, 6'((x * 5 + y * 11) % 64)};
    endfunction

    function automatic pins_t model(int d, int tc);
        pins_t m;
        int ht, vt, p, q, qx, qy;
        logic [6:0] mc;
        logic [5:0] c;
        ht = CFG_HV[d] + CFG_HF[d] + CFG_HS[d] + CFG_HB[d];
        vt = CFG_VV[d] + CFG_VF[d] + CFG_VS[d] + CFG_VB[d];
        p  = tc / 2;
        q  = p - 1 - CFG_LAT[d];
        m.x    = 11'(p % ht);
        m.y    = 11'((p / ht) % vt);
        m.vclk = (tc % 2) == 1;
        m.fs   = m.vclk && (p % ht) == 0 && ((p / ht) % vt) == 0;
        m.hs   = 1'b1;
        m.vs   = 1'b1;
        m.bl   = 1'b0;
        m.rgb  = '0;
        if (q >= 0) begin
            qx = q % ht;
            qy = (q / ht) % vt;
            m.hs = !(qx >= CFG_HV[d] + CFG_HF[d] && qx < CFG_HV[d] + CFG_HF[d] + CFG_HS[d]);
            m.vs = !(qy >= CFG_VV[d] + CFG_VF[d] && qy < CFG_VV[d] + CFG_VF[d] + CFG_VS[d]);
            if (qx < CFG_HV[d] && qy < CFG_VV[d]) begin
                mc = mapper(qx, qy);
                c  = mc[6] ? mc[5:0] : CFG_BG[d];
                m.bl  = 1'b1;
                m.rgb = {8'(c[5:4] * 85), 8'(c[3:2] * 85), 8'(c[1:0] * 85)};
            end
        end
        return m;
    endfunction

    task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s dut%0d t=%0d got %h want %h", nm, d, t, got, exp);
        end
    endtask

    // Mapper drive: real data on pix_en cycles, noise otherwise.
    initial begin
        int k, ht, vt;
        logic [6:0] mc;
        for (int d = 0; d < N; d++) begin
            col[d] = '0;
            drw[d] = 1'b0;
        end
        forever begin
            @(negedge Clk);
            #1;
            for (int d = 0; d < N; d++) begin
                k  = t / 2 - CFG_LAT[d];
                ht = CFG_HV[d] + CFG_HF[d] + CFG_HS[d] + CFG_HB[d];
                vt = CFG_VV[d] + CFG_VF[d] + CFG_VS[d] + CFG_VB[d];
                if ((t % 2) == 1 && k >= 0) begin
                    mc = mapper(k % ht, (k / ht) % vt);
                    drw[d] = mc[6];
                    col[d] = mc[5:0];
                end else begin
                    col[d] = 6'($urandom);
                    drw[d] = 1'($urandom);
                end
            end
        end
    end

    int hs_f1, hs_r1, hs_f2, fs_c1, fs_c2, vs_cf, vs_cr;
    logic prev_hs, prev_vs;

    always @(negedge Clk) begin
        pins_t m;
        if (armed) begin
            for (int d = 0; d < N; d++) begin
                m = model(d, t);
                chk("vga_x", d, 32'(vx[d]), 32'(m.x));
                chk("vga_y", d, 32'(vy[d]), 32'(m.y));
                chk("frame_start", d, 32'(fs[d]), 32'(m.fs));
                chk("VGA_CLK", d, 32'(vclk[d]), 32'(m.vclk));
                chk("VGA_HS", d, 32'(hs[d]), 32'(m.hs));
                chk("VGA_VS", d, 32'(vs[d]), 32'(m.vs));
                chk("VGA_BLANK_N", d, 32'(bl[d]), 32'(m.bl));
                chk("VGA_SYNC_N", d, 32'(sn[d]), 32'd0);
                chk("rgb", d, 32'({r[d], g[d], b[d]}), 32'(m.rgb));
            end

            // Hand-computed anchors for the model.
            if (t == 0) begin
                chk("rst_hs", 0, 32'(hs[0]), 32'd1);
                chk("rst_vs", 0, 32'(vs[0]), 32'd1);
                chk("rst_blank", 0, 32'(bl[0]), 32'd0);
                chk("rst_rgb", 0, 32'({r[0], g[0], b[0]}), 32'd0);
                chk("rst_fs", 0, 32'(fs[0]), 32'd0);
                chk("rst_vclk", 0, 32'(vclk[0]), 32'd0);
                chk("rst_x", 0, 32'(vx[0]), 32'd0);
                chk("rst_dly_hs", 1, 32'(hs[1]), 32'd1);
            end
            if (t == 1) begin
                chk("x_hold", 0, 32'(vx[0]), 32'd0);
                chk("first_fs", 0, 32'(fs[0]), 32'd1);
            end
            if (t == 2) chk("x_step", 0, 32'(vx[0]), 32'd1);
            if (t == 30) begin
                chk("bg_rgb", 1, 32'({r[1], g[1], b[1]}), 32'hFFFFFF);
                chk("bg_blank", 1, 32'(bl[1]), 32'd1);
            end
            if (t == 1406) begin
                chk("hblank_rgb", 1, 32'({r[1], g[1], b[1]}), 32'd0);
                chk("hblank_blank", 1, 32'(bl[1]), 32'd0);
            end
            if (t == 8026) begin
                chk("spr_rgb", 1, 32'({r[1], g[1], b[1]}), 32'hFF5500);
                chk("spr_x", 1, 32'(vx[1]), 32'd13);
            end
            if (t >= 1400 && (t % 1600) == 1400) chk("hs_in_pulse", 0, 32'(hs[0]), 32'd0);
            if (t == 3000) begin
                chk("hs_fall1", 0, 32'(hs_f1), 32'd1314);
                chk("hs_rise1", 0, 32'(hs_r1), 32'd1506);
                chk("hs_fall2", 0, 32'(hs_f2), 32'd2914);
                chk("fs_first", 2, 32'(fs_c1), 32'd1);
                chk("fs_second", 2, 32'(fs_c2), 32'd271);
                chk("vs_fall", 2, 32'(vs_cf), 32'd154);
                chk("vs_rise", 2, 32'(vs_cr), 32'd214);
            end

            if (t == 0) begin
                hs_f1 = -1; hs_r1 = -1; hs_f2 = -1;
                fs_c1 = -1; fs_c2 = -1; vs_cf = -1; vs_cr = -1;
            end else begin
                if (prev_hs && !hs[0]) begin
                    if (hs_f1 < 0) hs_f1 = t;
                    else if (hs_f2 < 0) hs_f2 = t;
                end
                if (!prev_hs && hs[0] && hs_f1 >= 0 && hs_r1 < 0) hs_r1 = t;
                if (fs[2]) begin
                    if (fs_c1 < 0) fs_c1 = t;
                    else if (fs_c2 < 0) fs_c2 = t;
                end
                if (prev_vs && !vs[2] && vs_cf < 0) vs_cf = t;
                if (!prev_vs && vs[2] && vs_cf >= 0 && vs_cr < 0) vs_cr = t;
            end
            prev_hs = hs[0];
            prev_vs = vs[2];
        end
    end

    initial begin
        Reset = 1'b1;
        @(posedge Clk);
        armed = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        // Run until h=700 on the default raster, then reset inside the HS pulse.
        repeat (9400) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3100) @(negedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
